// File: rtl/scan_pattern_ctrl_if.sv
// Bus between the scan self-test sequencer and its surroundings: the test-control
// handshake, the pattern ROM port and the core's scan port.
interface scan_pattern_ctrl_if #(
  parameter int ADDR_W = 6
);
  logic              start;
  logic              busy;
  logic              done;
  logic [ADDR_W-1:0] Address;
  logic [7:0]        DataOut;
  logic [3:0]        ScanChainIN;
  logic [3:0]        ScanChainOut;
  logic              SCANMODE;
  logic [15:0]       signature;

  modport master (
    input  start, DataOut, ScanChainOut,
    output busy, done, Address, ScanChainIN, SCANMODE, signature
  );

  modport slave (
    output start, DataOut, ScanChainOut,
    input  busy, done, Address, ScanChainIN, SCANMODE, signature
  );
endinterface

// File: rtl/scan_pattern_ctrl.sv
// Scan self-test sequencer: shifts ROM patterns into four scan chains, pulses capture,
// and folds the chain outputs into a 16-bit MISR signature.
module scan_pattern_ctrl #(
  parameter int CHAIN_LEN    = 8,
  parameter int NUM_PATTERNS = 16,
  parameter int ADDR_W       = 6
) (
  input  logic                CLK,
  input  logic                CoreIN_RESET,
  scan_pattern_ctrl_if.master bus
);

  localparam int CNT_W = (CHAIN_LEN > 1) ? $clog2(CHAIN_LEN) : 1;
  localparam int PAT_W = $clog2(NUM_PATTERNS + 1);
  localparam logic [CNT_W-1:0] LAST_SHIFT = CNT_W'(CHAIN_LEN - 1);
  localparam logic [PAT_W-1:0] LAST_PAT   = PAT_W'(NUM_PATTERNS - 1);

  typedef enum logic [2:0] {
    IDLE,
    SHIFT,
    CAPTURE,
    UNLOAD,
    DONE
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] shiftCnt;
  logic [PAT_W-1:0] patCnt;
  logic [15:0]      sigReg;
  logic [15:0]      misrNext;

  // Polynomial x^16+x^12+x^5+1 with the four chain outputs injected at the low end.
  assign misrNext = {sigReg[14:0], 1'b0}
                  ^ (sigReg[15] ? 16'h1021 : 16'h0000)
                  ^ {12'b0, bus.ScanChainOut};

  // NOTE: state is updated with <= so every register sees pre-edge values of the others.
  always_ff @(posedge CLK) begin
    if (!CoreIN_RESET) begin
      state    <= IDLE;
      shiftCnt <= '0;
      patCnt   <= '0;
      sigReg   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            sigReg   <= '0;
            patCnt   <= '0;
            shiftCnt <= '0;
            state    <= SHIFT;
          end
        end
        SHIFT: begin
          // Pattern 0 unloads chain contents left over from reset, so it is not compressed.
          if (patCnt != '0) sigReg <= misrNext;
          if (shiftCnt == LAST_SHIFT) begin
            shiftCnt <= '0;
            state    <= CAPTURE;
          end else begin
            shiftCnt <= shiftCnt + CNT_W'(1);
          end
        end
        CAPTURE: begin
          patCnt <= patCnt + PAT_W'(1);
          state  <= (patCnt == LAST_PAT) ? UNLOAD : SHIFT;
        end
        UNLOAD: begin
          sigReg <= misrNext;
          if (shiftCnt == LAST_SHIFT) begin
            shiftCnt <= '0;
            state    <= DONE;
          end else begin
            shiftCnt <= shiftCnt + CNT_W'(1);
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  logic [ADDR_W-1:0] addrOut;
  logic [3:0]        scanIn;
  logic              scanMode;
  logic              busyOut;
  logic              doneOut;

  // NOTE: every output gets a default first, so no path through the case infers a latch.
  always_comb begin
    addrOut  = '0;
    scanIn   = '0;
    scanMode = 1'b0;
    busyOut  = 1'b0;
    doneOut  = 1'b0;
    case (state)
      SHIFT: begin
        busyOut  = 1'b1;
        scanMode = 1'b1;
        // Each ROM byte feeds two shift cycles: low nibble first, then high nibble.
        addrOut  = ADDR_W'(int'(patCnt) * (CHAIN_LEN / 2) + int'(shiftCnt >> 1));
        scanIn   = shiftCnt[0] ? bus.DataOut[7:4] : bus.DataOut[3:0];
      end
      CAPTURE: busyOut = 1'b1;
      UNLOAD: begin
        busyOut  = 1'b1;
        scanMode = 1'b1;
      end
      DONE:    doneOut = 1'b1;
      default: ;
    endcase
  end

  assign bus.Address     = addrOut;
  assign bus.ScanChainIN = scanIn;
  assign bus.SCANMODE    = scanMode;
  assign bus.busy        = busyOut;
  assign bus.done        = doneOut;
  assign bus.signature   = sigReg;

endmodule

// File: tb/tb_scan_pattern_ctrl.sv
// Directed-plus-random bench for scan_pattern_ctrl; expected behaviour is derived per
// busy cycle from the run's timeline arithmetic and a behavioural MISR.
module tb_scan_pattern_ctrl;

  localparam int CL   = 8;
  localparam int NP   = 16;
  localparam int BUSY = NP * (CL + 1) + CL;

  logic clk;
  logic rst_n;
  int   tests = 0;
  int   fails = 0;

  logic [7:0] rom [64];
  logic [3:0] firstSin [4] = '{4'h5, 4'hA, 4'hC, 4'h3};

  scan_pattern_ctrl_if #(.ADDR_W(6)) bus ();

  scan_pattern_ctrl #(
    .CHAIN_LEN   (CL),
    .NUM_PATTERNS(NP),
    .ADDR_W      (6)
  ) dut (
    .CLK         (clk),
    .CoreIN_RESET(rst_n),
    .bus         (bus)
  );

  assign bus.DataOut = rom[bus.Address];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic checkIdle(input logic [15:0] expSig);
    check("idle_busy", 32'(bus.busy), 32'(0));
    check("idle_done", 32'(bus.done), 32'(0));
    check("idle_scanmode", 32'(bus.SCANMODE), 32'(0));
    check("idle_addr", 32'(bus.Address), 32'(0));
    check("idle_sin", 32'(bus.ScanChainIN), 32'(0));
    check("idle_sig", 32'(bus.signature), 32'(expSig));
  endtask

  function automatic logic [3:0] soVal(input int mode, input int k);
    case (mode)
      0:       return 4'($urandom);
      2:       return (k == BUSY - 1) ? 4'h1 : 4'h0;
      3:       return (k == BUSY - 2) ? 4'h1 : 4'h0;
      4:       return (k < CL) ? 4'hF : 4'h0;
      default: return 4'h0;
    endcase
  endfunction

  // One run from IDLE: busy cycle k belongs to pattern k/(CL+1); position CL within a
  // pattern is the capture cycle; the last CL cycles are the unload.
  task automatic run(input int mode, input bit directed, input bit hold,
                     input int abortAt, input int expConst);
    logic [15:0] sig;
    logic [7:0]  d;
    logic [5:0]  expAddr;
    logic [3:0]  expSin;
    logic [3:0]  so;
    bit          shift, capt, unload;
    int          p, s;
    sig = '0;
    bus.start = 1'b1;
    @(posedge clk); #1;
    if (!hold) bus.start = 1'b0;
    for (int k = 0; k < BUSY; k++) begin
      so = soVal(mode, k);
      bus.ScanChainOut = so;
      p = k / (CL + 1);
      s = k % (CL + 1);
      unload  = (k >= NP * (CL + 1));
      shift   = !unload && (s < CL);
      capt    = !unload && (s == CL);
      expAddr = shift ? 6'(p * (CL / 2) + s / 2) : 6'd0;
      d       = rom[expAddr];
      expSin  = shift ? ((s % 2 == 1) ? d[7:4] : d[3:0]) : 4'h0;
      if (k == abortAt) rst_n = 1'b0;
      @(negedge clk);
      check("busy", 32'(bus.busy), 32'(1));
      check("done_in_run", 32'(bus.done), 32'(0));
      check("scanmode", 32'(bus.SCANMODE), 32'(!capt));
      check("addr", 32'(bus.Address), 32'(expAddr));
      check("sin", 32'(bus.ScanChainIN), 32'(expSin));
      if (directed && k < 4) begin
        check("first_addr", 32'(bus.Address), 32'(k / 2));
        check("first_sin", 32'(bus.ScanChainIN), 32'(firstSin[k]));
      end
      @(posedge clk); #1;
      if (k == abortAt) begin
        rst_n = 1'b1;
        @(negedge clk);
        checkIdle(16'h0000);
        @(posedge clk); #1;
        @(negedge clk);
        checkIdle(16'h0000);
        return;
      end
      if ((shift && p > 0) || unload)
        sig = {sig[14:0], 1'b0} ^ (sig[15] ? 16'h1021 : 16'h0000) ^ {12'b0, so};
    end
    bus.ScanChainOut = 4'h0;
    @(negedge clk);
    check("done_pulse", 32'(bus.done), 32'(1));
    check("done_busy", 32'(bus.busy), 32'(0));
    check("done_scanmode", 32'(bus.SCANMODE), 32'(0));
    check("done_sig", 32'(bus.signature), 32'(sig));
    if (expConst >= 0) check("sig_const", 32'(bus.signature), 32'(expConst));
    @(posedge clk); #1;
    @(negedge clk);
    checkIdle(sig);
  endtask

  initial begin
    rst_n = 1'b0;
    bus.start = 1'b0;
    bus.ScanChainOut = 4'h0;
    for (int i = 0; i < 64; i++) rom[i] = 8'($urandom);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checkIdle(16'h0000);
    end

    rom[0] = 8'hA5;
    rom[1] = 8'h3C;
    run(0, 1'b1, 1'b0, -1, -1);

    for (int i = 0; i < 64; i++) rom[i] = 8'h00;
    run(1, 1'b0, 1'b0, -1, 16'h0000);

    for (int i = 0; i < 64; i++) rom[i] = 8'($urandom);
    run(2, 1'b0, 1'b0, -1, 16'h0001);
    run(3, 1'b0, 1'b0, -1, 16'h0002);
    run(4, 1'b0, 1'b0, -1, 16'h0000);

    run(0, 1'b0, 1'b0, 5 * (CL + 1) + 3, -1);
    run(0, 1'b0, 1'b0, -1, -1);

    run(0, 1'b0, 1'b1, -1, -1);
    run(0, 1'b0, 1'b0, -1, -1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
